// File: rtl/i2c_slave_controller_pkg.sv
// i2c_slave_ctrl_pkg: shared state encoding and byte/address constants for the I2C slave.
package i2c_slave_ctrl_pkg;
    localparam int BYTE_W = 8;
    localparam int ADDR_W = 7;
    localparam logic [BYTE_W-1:0] UNDERRUN_BYTE = 8'hFF;
    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, IGNORE
    } i2c_slave_state_e;
endpackage

// File: rtl/i2c_slave_controller_if.sv
// i2c_slave_controller_if: pad and byte-stream signals of the I2C slave; slave = DUT side.
interface i2c_slave_controller_if;
    import i2c_slave_ctrl_pkg::*;
    logic              scl_i;
    logic              sda_i;
    logic              sda_oe_o;
    logic              scl_oe_o;
    logic [BYTE_W-1:0] rx_data_o;
    logic              rx_valid_o;
    logic              rx_full_i;
    logic [BYTE_W-1:0] tx_data_i;
    logic              tx_valid_i;
    logic              tx_req_o;
    logic              busy_o;
    logic              addressed_o;
    logic              rw_o;
    logic              stop_o;
    modport slave (
        input  scl_i, sda_i, rx_full_i, tx_data_i, tx_valid_i,
        output sda_oe_o, scl_oe_o, rx_data_o, rx_valid_o, tx_req_o, busy_o, addressed_o, rw_o, stop_o
    );
    modport master (
        output scl_i, sda_i, rx_full_i, tx_data_i, tx_valid_i,
        input  sda_oe_o, scl_oe_o, rx_data_o, rx_valid_o, tx_req_o, busy_o, addressed_o, rw_o, stop_o
    );
endinterface

// File: rtl/i2c_bus_sync_detect.sv
// i2c_bus_sync_detect: synchronizes SCL/SDA and derives SCL edges plus START/STOP pulses.
module i2c_bus_sync_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic pclk,
    input  logic areset,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);
    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_prev_q, sda_prev_q;
    logic                   scl_s;
    // Reset to 1 so an idle bus produces no edges when reset releases.
    always_ff @(posedge pclk or posedge areset) begin
        if (areset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
            sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
        end
    end
    assign scl_s      = scl_sync_q[SYNC_STAGES-1];
    assign sda_o      = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise_o = scl_s & ~scl_prev_q;
    assign scl_fall_o = ~scl_s & scl_prev_q;
    assign start_o    = scl_s & scl_prev_q & sda_prev_q & ~sda_o;
    assign stop_o     = scl_s & scl_prev_q & ~sda_prev_q & sda_o;
endmodule

// File: rtl/i2c_slave_controller.sv
// i2c_slave_controller: I2C slave protocol engine (address match, ACK/NACK, byte RX/TX).
// Define I2C_SLAVE_CLK_STRETCH_EN to stretch SCL on TX underrun / RX full instead of FF/NACK.
module i2c_slave_controller
    import i2c_slave_ctrl_pkg::*;
#(
    parameter logic [ADDR_W-1:0] SLAVE_ADDR  = 7'h68,
    parameter int                SYNC_STAGES = 2
) (
    input logic                   pclk,
    input logic                   areset,
    i2c_slave_controller_if.slave bus
);
`ifdef I2C_SLAVE_CLK_STRETCH_EN
    localparam bit STRETCH = 1'b1;
`else
    localparam bit STRETCH = 1'b0;
`endif
    i2c_slave_state_e  state_q, state_d;
    logic [BYTE_W-1:0] shift_q, shift_d, rx_data_q, rx_data_d, tx_byte;
    logic [3:0]        cnt_q, cnt_d;
    logic              sda_oe_q, sda_oe_d, scl_oe_q, scl_oe_d, ack_q, ack_d;
    logic              addressed_q, addressed_d, rw_q, rw_d, busy_q, busy_d;
    logic              rx_valid_q, rx_valid_d, tx_req_q, tx_req_d, stop_q, stop_d;
    logic              sda, scl_rise, scl_fall, start, stop;

    i2c_bus_sync_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .pclk(pclk), .areset(areset), .scl_i(bus.scl_i), .sda_i(bus.sda_i),
        .sda_o(sda), .scl_rise_o(scl_rise), .scl_fall_o(scl_fall), .start_o(start), .stop_o(stop)
    );

    assign tx_byte = bus.tx_valid_i ? bus.tx_data_i : UNDERRUN_BYTE;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        sda_oe_d    = sda_oe_q;
        scl_oe_d    = scl_oe_q;
        ack_d       = ack_q;
        addressed_d = addressed_q;
        rw_d        = rw_q;
        busy_d      = busy_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        tx_req_d    = 1'b0;
        stop_d      = 1'b0;
        if (stop) begin
            state_d     = IDLE;
            cnt_d       = '0;
            sda_oe_d    = 1'b0;
            scl_oe_d    = 1'b0;
            busy_d      = 1'b0;
            addressed_d = 1'b0;
            stop_d      = 1'b1;
        end else if (start) begin
            state_d     = ADDR;
            cnt_d       = '0;
            sda_oe_d    = 1'b0;
            scl_oe_d    = 1'b0;
            busy_d      = 1'b1;
            addressed_d = 1'b0;
        end else begin
            case (state_q)
                ADDR: if (scl_rise) begin
                    shift_d = {shift_q[BYTE_W-2:0], sda};
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        cnt_d       = '0;
                        addressed_d = shift_q[ADDR_W-1:0] == SLAVE_ADDR;
                        rw_d        = shift_q[ADDR_W-1:0] == SLAVE_ADDR ? sda : rw_q;
                        state_d     = shift_q[ADDR_W-1:0] == SLAVE_ADDR ? ADDR_ACK : IGNORE;
                    end
                end
                ADDR_ACK: if (scl_fall) sda_oe_d = 1'b1;
                    else if (scl_rise) begin
                        tx_req_d = rw_q;
                        state_d  = rw_q ? TX_BYTE : RX_BYTE;
                    end
                RX_BYTE: if (scl_fall) sda_oe_d = 1'b0;
                    else if (scl_rise) begin
                        shift_d = {shift_q[BYTE_W-2:0], sda};
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            cnt_d      = '0;
                            rx_data_d  = {shift_q[BYTE_W-2:0], sda};
                            rx_valid_d = 1'b1;
                            ack_d      = STRETCH | ~bus.rx_full_i;
                            state_d    = RX_ACK;
                        end
                    end
                // While stretched: drive ACK first, release SCL one pclk later.
                RX_ACK: if (scl_oe_q) begin
                        if (sda_oe_q) scl_oe_d = 1'b0;
                        else if (!bus.rx_full_i) sda_oe_d = 1'b1;
                    end else if (scl_fall) begin
                        if (STRETCH && bus.rx_full_i) scl_oe_d = 1'b1;
                        else sda_oe_d = ack_q;
                    end else if (scl_rise) state_d = ack_q ? RX_BYTE : IGNORE;
                TX_BYTE: if (scl_oe_q) begin
                        if (cnt_q != 4'd0) scl_oe_d = 1'b0;
                        else if (bus.tx_valid_i) begin
                            sda_oe_d = ~tx_byte[BYTE_W-1];
                            shift_d  = {tx_byte[BYTE_W-2:0], 1'b0};
                            cnt_d    = 4'd1;
                        end
                    end else if (scl_fall) begin
                        if (cnt_q == 4'd0) begin
                            if (STRETCH && !bus.tx_valid_i) begin
                                scl_oe_d = 1'b1;
                                sda_oe_d = 1'b0;
                            end else begin
                                sda_oe_d = ~tx_byte[BYTE_W-1];
                                shift_d  = {tx_byte[BYTE_W-2:0], 1'b0};
                                cnt_d    = 4'd1;
                            end
                        end else if (cnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            cnt_d    = '0;
                            state_d  = TX_ACK;
                        end else begin
                            sda_oe_d = ~shift_q[BYTE_W-1];
                            shift_d  = {shift_q[BYTE_W-2:0], 1'b0};
                            cnt_d    = cnt_q + 4'd1;
                        end
                    end
                TX_ACK: if (scl_rise) begin
                    tx_req_d = ~sda;
                    state_d  = sda ? IGNORE : TX_BYTE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge pclk or posedge areset) begin
        if (areset) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            sda_oe_q    <= 1'b0;
            scl_oe_q    <= 1'b0;
            ack_q       <= 1'b0;
            addressed_q <= 1'b0;
            rw_q        <= 1'b0;
            busy_q      <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            tx_req_q    <= 1'b0;
            stop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            sda_oe_q    <= sda_oe_d;
            scl_oe_q    <= scl_oe_d;
            ack_q       <= ack_d;
            addressed_q <= addressed_d;
            rw_q        <= rw_d;
            busy_q      <= busy_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_req_q    <= tx_req_d;
            stop_q      <= stop_d;
        end
    end

    assign bus.sda_oe_o    = sda_oe_q;
    assign bus.scl_oe_o    = STRETCH & scl_oe_q;
    assign bus.rx_data_o   = rx_data_q;
    assign bus.rx_valid_o  = rx_valid_q;
    assign bus.tx_req_o    = tx_req_q;
    assign bus.busy_o      = busy_q;
    assign bus.addressed_o = addressed_q;
    assign bus.rw_o        = rw_q;
    assign bus.stop_o      = stop_q;
endmodule

// File: tb/tb_i2c_slave_controller.sv
// tb_i2c_slave_controller: I2C master bus model driving the slave, with RX/TX byte scoreboards.
module tb_i2c_slave_controller;
    import i2c_slave_ctrl_pkg::*;
    localparam int Q = 100;
    logic       pclk = 1'b0, areset = 1'b1, scl_m = 1'b1, sda_m = 1'b1, rx_full = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       scl, sda;
    int         checks = 0, errors = 0;
    int         stop_cnt = 0, tx_req_cnt = 0, sda_drive_cnt = 0, stretch_cyc = 0;
    logic [7:0] rx_got[$], rx_exp[$], tx_src[$], tx_exp[$];

    i2c_slave_controller_if bus();
    assign scl = scl_m & ~bus.scl_oe_o;
    assign sda = sda_m & ~bus.sda_oe_o;
    assign bus.scl_i      = scl;
    assign bus.sda_i      = sda;
    // The consumer drains after being stretched for a while; without stretching this is plain rx_full.
    assign bus.rx_full_i  = rx_full && (stretch_cyc < 50);
    assign bus.tx_data_i  = tx_data;
    assign bus.tx_valid_i = tx_valid;

    i2c_slave_controller #(.SLAVE_ADDR(7'h68), .SYNC_STAGES(2)) dut (
        .pclk(pclk), .areset(areset), .bus(bus)
    );

    always #5 pclk = ~pclk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial forever begin
        @(negedge pclk);
        if (bus.rx_valid_o) rx_got.push_back(bus.rx_data_o);
        if (bus.stop_o) stop_cnt++;
        if (bus.sda_oe_o) sda_drive_cnt++;
        if (bus.scl_oe_o) stretch_cyc++;
        if (bus.tx_req_o) begin
            tx_req_cnt++;
            tx_valid = tx_src.size() > 0;
            if (tx_src.size() > 0) tx_data = tx_src.pop_front();
        end
    end

    task automatic scl_high;
        int n = 0;
        scl_m = 1'b1;
        while (scl !== 1'b1 && n < 3000) begin
            @(negedge pclk);
            n++;
        end
        checks++;
        if (scl !== 1'b1) begin
            errors++;
            $display("FAIL scl_release: scl=%b required 1", scl);
        end
    endtask

    task automatic xfer_bit(input logic b, output logic r);
        sda_m = b;
        #Q;
        scl_high();
        #Q;
        r = sda;
        #Q;
        scl_m = 1'b0;
        #Q;
    endtask

    task automatic bus_start;
        sda_m = 1'b1;
        #Q;
        scl_high();
        #Q;
        sda_m = 1'b0;
        #Q;
        scl_m = 1'b0;
        #Q;
    endtask

    task automatic bus_stop;
        sda_m = 1'b0;
        #Q;
        scl_high();
        #Q;
        sda_m = 1'b1;
        #Q;
        repeat (4) @(negedge pclk);
    endtask

    task automatic wr_byte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) xfer_bit(d[i], r);
        xfer_bit(1'b1, r);
        ack = ~r;
    endtask

    task automatic rd_byte(output logic [7:0] d, input logic mack);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            xfer_bit(1'b1, r);
            d[i] = r;
        end
        xfer_bit(~mack, r);
    endtask

    task automatic test_reset;
        areset = 1'b1;
        repeat (3) @(negedge pclk);
        checks++;
        if ({bus.sda_oe_o, bus.scl_oe_o, bus.rx_data_o, bus.rx_valid_o, bus.tx_req_o, bus.busy_o,
             bus.addressed_o, bus.rw_o, bus.stop_o} !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs: got sda_oe=%b busy=%b addressed=%b rx_data=%h required all 0",
                     bus.sda_oe_o, bus.busy_o, bus.addressed_o, bus.rx_data_o);
        end
        checks++;
        if (dut.state_q !== IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d required %0d", dut.state_q, IDLE);
        end
        areset = 1'b0;
        repeat (5) @(negedge pclk);
    endtask

    task automatic test_write;
        logic [7:0] data[2] = '{8'h5A, 8'h3C};
        logic       ack;
        int         s0 = stop_cnt;
        rx_got.delete();
        bus_start();
        wr_byte(8'hD0, ack);
        checks++;
        if (ack !== 1'b1) begin
            errors++;
            $display("FAIL write_addr_ack: got %b required 1", ack);
        end
        checks++;
        if ({bus.busy_o, bus.addressed_o, bus.rw_o} !== 3'b110) begin
            errors++;
            $display("FAIL write_status: busy/addressed/rw got %b required 110",
                     {bus.busy_o, bus.addressed_o, bus.rw_o});
        end
        foreach (data[i]) begin
            rx_exp.push_back(data[i]);
            wr_byte(data[i], ack);
            checks++;
            if (ack !== 1'b1) begin
                errors++;
                $display("FAIL write_data_ack[%0d]: got %b required 1", i, ack);
            end
        end
        bus_stop();
        checks++;
        if (rx_got.size() != rx_exp.size()) begin
            errors++;
            $display("FAIL write_rx_count: got %0d required %0d", rx_got.size(), rx_exp.size());
        end
        while (rx_got.size() > 0 && rx_exp.size() > 0) begin
            logic [7:0] g = rx_got.pop_front(), e = rx_exp.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL write_rx_data: got %h required %h", g, e);
            end
        end
        rx_exp.delete();
        checks++;
        if (stop_cnt - s0 != 1) begin
            errors++;
            $display("FAIL write_stop_pulses: got %0d required 1", stop_cnt - s0);
        end
        checks++;
        if ({bus.busy_o, bus.addressed_o} !== 2'b00) begin
            errors++;
            $display("FAIL write_after_stop: busy/addressed got %b required 00", {bus.busy_o, bus.addressed_o});
        end
    endtask

    task automatic test_nomatch;
        logic ack;
        int   d0 = sda_drive_cnt;
        rx_got.delete();
        bus_start();
        wr_byte(8'hD2, ack);
        checks++;
        if (ack !== 1'b0) begin
            errors++;
            $display("FAIL nomatch_addr_ack: got %b required 0", ack);
        end
        wr_byte(8'h55, ack);
        checks++;
        if (ack !== 1'b0) begin
            errors++;
            $display("FAIL nomatch_data_ack: got %b required 0", ack);
        end
        checks++;
        if (dut.state_q !== IGNORE || bus.addressed_o !== 1'b0) begin
            errors++;
            $display("FAIL nomatch_state: got state %0d addressed %b required %0d 0",
                     dut.state_q, bus.addressed_o, IGNORE);
        end
        bus_stop();
        checks++;
        if (sda_drive_cnt != d0 || rx_got.size() != 0) begin
            errors++;
            $display("FAIL nomatch_quiet: sda driven %0d cycles, %0d rx bytes, required 0 0",
                     sda_drive_cnt - d0, rx_got.size());
        end
        checks++;
        if (dut.state_q !== IDLE) begin
            errors++;
            $display("FAIL nomatch_idle: got %0d required %0d", dut.state_q, IDLE);
        end
    endtask

    task automatic test_read;
        logic [7:0] d, e;
        logic       ack;
        int         q0 = tx_req_cnt;
        tx_src.push_back(8'hA5);
        tx_exp.push_back(8'hA5);
        tx_src.push_back(8'h0F);
        tx_exp.push_back(8'h0F);
        bus_start();
        wr_byte(8'hD1, ack);
        checks++;
        if ({ack, bus.addressed_o, bus.rw_o} !== 3'b111) begin
            errors++;
            $display("FAIL read_addr: ack/addressed/rw got %b required 111", {ack, bus.addressed_o, bus.rw_o});
        end
        for (int i = 0; i < 2; i++) begin
            rd_byte(d, i == 0);
            e = tx_exp.pop_front();
            checks++;
            if (d !== e) begin
                errors++;
                $display("FAIL read_byte[%0d]: got %h required %h", i, d, e);
            end
        end
        checks++;
        if (dut.state_q !== IGNORE) begin
            errors++;
            $display("FAIL read_nack_state: got %0d required %0d", dut.state_q, IGNORE);
        end
        checks++;
        if (tx_req_cnt - q0 != 2) begin
            errors++;
            $display("FAIL read_tx_req: got %0d pulses required 2", tx_req_cnt - q0);
        end
        bus_stop();
    endtask

    task automatic test_repeated_start;
        logic [7:0] d;
        logic       ack;
        int         q0;
        rx_got.delete();
        rx_exp.push_back(8'h11);
        bus_start();
        wr_byte(8'hD0, ack);
        wr_byte(8'h11, ack);
        tx_src.push_back(8'h77);
        tx_exp.push_back(8'h77);
        q0 = tx_req_cnt;
        bus_start();
        wr_byte(8'hD1, ack);
        checks++;
        if ({ack, bus.addressed_o, bus.rw_o, bus.busy_o} !== 4'b1111) begin
            errors++;
            $display("FAIL rstart_addr: ack/addressed/rw/busy got %b required 1111",
                     {ack, bus.addressed_o, bus.rw_o, bus.busy_o});
        end
        checks++;
        if (tx_req_cnt - q0 != 1) begin
            errors++;
            $display("FAIL rstart_tx_req: got %0d pulses required 1", tx_req_cnt - q0);
        end
        rd_byte(d, 1'b0);
        checks++;
        if (d !== tx_exp[0]) begin
            errors++;
            $display("FAIL rstart_read: got %h required %h", d, tx_exp[0]);
        end
        tx_exp.delete();
        bus_stop();
        checks++;
        if (rx_got.size() != 1 || rx_got[0] !== rx_exp[0]) begin
            errors++;
            $display("FAIL rstart_rx: got %0d bytes first %h required 1 byte %h",
                     rx_got.size(), rx_got.size() > 0 ? rx_got[0] : 8'hxx, rx_exp[0]);
        end
        rx_exp.delete();
    endtask

    task automatic test_rx_full;
        logic ack;
        rx_got.delete();
        rx_exp.push_back(8'hAA);
        rx_exp.push_back(8'hBB);
        bus_start();
        wr_byte(8'hD0, ack);
        wr_byte(8'hAA, ack);
        checks++;
        if (ack !== 1'b1) begin
            errors++;
            $display("FAIL rxfull_first_ack: got %b required 1", ack);
        end
        rx_full = 1'b1;
        wr_byte(8'hBB, ack);
`ifdef I2C_SLAVE_CLK_STRETCH_EN
        checks++;
        if (ack !== 1'b1 || stretch_cyc == 0 || dut.state_q !== RX_BYTE) begin
            errors++;
            $display("FAIL rxfull_stretch: ack %b stretch %0d state %0d required 1 >0 %0d",
                     ack, stretch_cyc, dut.state_q, RX_BYTE);
        end
`else
        checks++;
        if (ack !== 1'b0 || stretch_cyc != 0 || dut.state_q !== IGNORE) begin
            errors++;
            $display("FAIL rxfull_nack: ack %b stretch %0d state %0d required 0 0 %0d",
                     ack, stretch_cyc, dut.state_q, IGNORE);
        end
`endif
        rx_full = 1'b0;
        bus_stop();
        checks++;
        if (rx_got.size() != rx_exp.size()) begin
            errors++;
            $display("FAIL rxfull_rx_count: got %0d required %0d", rx_got.size(), rx_exp.size());
        end
        while (rx_got.size() > 0 && rx_exp.size() > 0) begin
            logic [7:0] g = rx_got.pop_front(), e = rx_exp.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL rxfull_rx_data: got %h required %h", g, e);
            end
        end
        rx_exp.delete();
    endtask

    task automatic test_reset_mid_tx;
        logic ack, r;
        tx_src.push_back(8'h00);
        bus_start();
        wr_byte(8'hD1, ack);
        repeat (3) xfer_bit(1'b1, r);
        checks++;
        if (bus.sda_oe_o !== 1'b1 || dut.state_q !== TX_BYTE) begin
            errors++;
            $display("FAIL midtx_driving: sda_oe %b state %0d required 1 %0d", bus.sda_oe_o, dut.state_q, TX_BYTE);
        end
        @(negedge pclk);
        areset = 1'b1;
        #1;
        checks++;
        if ({bus.sda_oe_o, bus.scl_oe_o, bus.rx_data_o, bus.rx_valid_o, bus.tx_req_o, bus.busy_o,
             bus.addressed_o, bus.rw_o, bus.stop_o} !== 16'h0) begin
            errors++;
            $display("FAIL midtx_reset_outputs: sda_oe=%b busy=%b addressed=%b rw=%b required all 0",
                     bus.sda_oe_o, bus.busy_o, bus.addressed_o, bus.rw_o);
        end
        checks++;
        if (dut.state_q !== IDLE) begin
            errors++;
            $display("FAIL midtx_reset_state: got %0d required %0d", dut.state_q, IDLE);
        end
        repeat (3) @(negedge pclk);
        areset = 1'b0;
        scl_m = 1'b1;
        sda_m = 1'b1;
        repeat (10) @(negedge pclk);
        checks++;
        if ({bus.busy_o, bus.sda_oe_o} !== 2'b00) begin
            errors++;
            $display("FAIL midtx_after_release: busy/sda_oe got %b required 00", {bus.busy_o, bus.sda_oe_o});
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_nomatch();
        test_read();
        test_repeated_start();
        test_rx_full();
        test_reset_mid_tx();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
